// File: rtl/mesh_router.sv
// mesh_router: five-port input-queued mesh router tile; define ANT_ROUTING_EN for pheromone adaptive routing
`ifndef N
`define N 5
`endif
`ifndef M
`define M 5
`endif
`ifndef X_NODES
`define X_NODES 4
`endif
`ifndef Y_NODES
`define Y_NODES 4
`endif
`ifndef NODES
`define NODES (`X_NODES*`Y_NODES)
`endif
`ifndef INPUT_QUEUE_DEPTH
`define INPUT_QUEUE_DEPTH 4
`endif
`ifndef PH_TABLE_DEPTH
`define PH_TABLE_DEPTH 4
`endif

package mesh_router_pkg;
  localparam int N = `N;
  localparam int M = `M;
  localparam int XN = `X_NODES;
  localparam int YN = `Y_NODES;
  localparam int NODES = `NODES;
  localparam int QD = `INPUT_QUEUE_DEPTH;
  localparam int D = `PH_TABLE_DEPTH;
  localparam int XW = XN > 1 ? $clog2(XN) : 1;
  localparam int YW = YN > 1 ? $clog2(YN) : 1;
  localparam int MEMS = 4;
  localparam int MW = $clog2(MEMS + 1);
  typedef struct packed {
    logic [XW-1:0] x_source;
    logic [YW-1:0] y_source;
    logic [XW-1:0] x_dest;
    logic [YW-1:0] y_dest;
    logic ant;
    logic backward;
    logic [MEMS-1:0][XW-1:0] x_memory;
    logic [MEMS-1:0][YW-1:0] y_memory;
    logic [MW-1:0] num_memories;
  } packet_t;
endpackage

module mesh_router
  import mesh_router_pkg::*;
#(
  parameter int X_LOC = 0,
  parameter int Y_LOC = 0
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  packet_t [0:N-1]                   i_data,
  input  logic    [0:N-1]                   i_data_val,
  output logic    [0:N-1]                   o_en,
  output packet_t [0:M-1]                   o_data,
  output logic    [0:M-1]                   o_data_val,
  input  logic    [0:M-1]                   i_en,
  output logic    [0:N-1]                   test_en_SCtoFF,
  output packet_t [0:N-1]                   test_data_FFtoAA,
  output logic    [0:N-1]                   test_data_val_FFtoAA,
  output packet_t [0:N-1]                   test_data_AAtoSW,
  output logic    [0:N-1]                   test_data_val_AAtoRC,
  output logic    [0:N-1][0:M-1]            test_output_req_AAtoRC,
  output logic    [0:N-1][0:M-1]            test_output_req_RCtoSC,
  output logic    [0:N-1][0:M-1]            test_l_req_matrix_SC,
  output logic    [0:N-1]                   test_update,
  output logic    [0:N-1]                   test_calculate_neighbor,
  output logic    [0:N-1][0:M-1]            test_r_o_output_req,
  output logic    [0:NODES-1][0:N-2][D-1:0] test_pheromones,
  output logic    [0:D-1]                   test_max_pheromone_value,
  output logic    [0:D-1]                   test_min_pheromone_value
);
  localparam int AW = QD > 1 ? $clog2(QD) : 1;
  localparam int CW = $clog2(QD + 1);
  localparam int NW = NODES > 1 ? $clog2(NODES) : 1;
  localparam logic [D-1:0] PH_INIT = D'(1 << (D - 1));
  localparam logic [XW-1:0] XL = XW'(X_LOC);
  localparam logic [YW-1:0] YL = YW'(Y_LOC);

  packet_t fifo_mem [N][QD];
  logic [AW-1:0] rd_ptr [N];
  logic [AW-1:0] wr_ptr [N];
  logic [CW-1:0] cnt [N];
  logic [0:N-1] wr;
  logic [0:N-1] full;
  logic [1:0] xi [N];
  logic [1:0] yi [N];
  logic [2:0] xy_port [N];
  logic [2:0] rc_port [N];
  logic [NW-1:0] dest [N];
  logic [0:M-1] gnt_v;
  logic [2:0] win [M];
  logic [2:0] rr [M];
  logic [0:NODES-1][0:N-2][D-1:0] ph;
  logic [D-1:0] ph_max_v;
  logic [D-1:0] ph_min_v;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(QD - 1) ? '0 : p + AW'(1);
  endfunction

  function automatic logic [2:0] wrap(input int v);
    return 3'(v >= N ? v - N : v);
  endfunction

  // FIFO status and first-word fall-through head
  always_comb
    for (int i = 0; i < N; i++) begin
      full[i] = cnt[i] == CW'(QD);
      o_en[i] = !full[i];
      test_data_FFtoAA[i] = fifo_mem[i][rd_ptr[i]];
      test_data_val_FFtoAA[i] = cnt[i] != '0;
      test_data_val_AAtoRC[i] = cnt[i] != '0;
    end

  // FIFO storage; a pop frees the slot so a full queue can still take a write that cycle
  always_ff @(posedge clk)
    if (!reset_n)
      for (int i = 0; i < N; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        cnt[i] <= '0;
      end
    else
      for (int i = 0; i < N; i++) begin
        if (wr[i]) begin
          fifo_mem[i][wr_ptr[i]] <= i_data[i];
          wr_ptr[i] <= nxt(wr_ptr[i]);
        end
        if (test_en_SCtoFF[i]) rd_ptr[i] <= nxt(rd_ptr[i]);
        cnt[i] <= cnt[i] + CW'(wr[i]) - CW'(test_en_SCtoFF[i]);
      end

  // forward ants record this tile in their path memory
  always_comb
    for (int i = 0; i < N; i++) begin
      test_data_AAtoSW[i] = test_data_FFtoAA[i];
`ifdef ANT_ROUTING_EN
      if (test_data_FFtoAA[i].ant && !test_data_FFtoAA[i].backward)
        for (int m = 0; m < MEMS; m++)
          if (test_data_FFtoAA[i].num_memories == MW'(m)) begin
            test_data_AAtoSW[i].x_memory[m] = XL;
            test_data_AAtoSW[i].y_memory[m] = YL;
            test_data_AAtoSW[i].num_memories = MW'(m + 1);
          end
`endif
    end

  // XY route, then pheromone choice between the two minimal directions (ties go X)
  always_comb
    for (int i = 0; i < N; i++) begin
      xi[i] = test_data_FFtoAA[i].x_dest > XL ? 2'd1 : 2'd3;
      yi[i] = test_data_FFtoAA[i].y_dest > YL ? 2'd0 : 2'd2;
      xy_port[i] = test_data_FFtoAA[i].x_dest != XL ? 3'(xi[i]) + 3'd1 :
                   test_data_FFtoAA[i].y_dest != YL ? 3'(yi[i]) + 3'd1 : 3'd0;
      dest[i] = NW'(test_data_FFtoAA[i].y_dest) * NW'(XN) + NW'(test_data_FFtoAA[i].x_dest);
`ifdef ANT_ROUTING_EN
      test_calculate_neighbor[i] = !test_data_FFtoAA[i].ant && test_data_FFtoAA[i].x_dest != XL &&
                                   test_data_FFtoAA[i].y_dest != YL;
`else
      test_calculate_neighbor[i] = 1'b0;
`endif
      rc_port[i] = test_calculate_neighbor[i] && ph[dest[i]][yi[i]] > ph[dest[i]][xi[i]] ?
                   3'(yi[i]) + 3'd1 : xy_port[i];
      for (int o = 0; o < M; o++) begin
        test_output_req_AAtoRC[i][o] = xy_port[i] == 3'(o);
        test_output_req_RCtoSC[i][o] = rc_port[i] == 3'(o);
        test_l_req_matrix_SC[i][o] = rc_port[i] == 3'(o) && test_data_val_FFtoAA[i];
      end
    end

  assign test_r_o_output_req = test_output_req_RCtoSC;

  // per-output round-robin arbitration starting at the pointer; grant pops the input
  always_comb begin
    test_en_SCtoFF = '0;
    for (int o = 0; o < M; o++) begin
      gnt_v[o] = 1'b0;
      win[o] = '0;
      for (int k = 0; k < N; k++)
        if (!gnt_v[o] && i_en[o] && test_l_req_matrix_SC[wrap(int'(rr[o]) + k)][o]) begin
          gnt_v[o] = 1'b1;
          win[o] = wrap(int'(rr[o]) + k);
        end
      if (gnt_v[o]) test_en_SCtoFF[win[o]] = 1'b1;
    end
    for (int i = 0; i < N; i++) wr[i] = i_data_val[i] && (!full[i] || test_en_SCtoFF[i]);
  end

  // registered crossbar; data holds when nothing is granted
  always_ff @(posedge clk)
    if (!reset_n) begin
      o_data <= '0;
      o_data_val <= '0;
      for (int o = 0; o < M; o++) rr[o] <= '0;
    end else
      for (int o = 0; o < M; o++) begin
        o_data_val[o] <= gnt_v[o];
        if (gnt_v[o]) begin
          o_data[o] <= test_data_AAtoSW[win[o]];
          rr[o] <= wrap(int'(win[o]) + 1);
        end
      end

`ifdef ANT_ROUTING_EN
  localparam logic [D-1:0] PH_MAX = '1;
  logic [NW-1:0] src [N];
  logic [0:NODES-1] row_hit;
  logic [0:NODES-1][0:N-2][D-1:0] ph_nxt;

  // forward ants reinforce the arrival port toward their source; lowest input owns a shared row
  always_comb begin
    ph_nxt = ph;
    row_hit = '0;
    for (int i = 0; i < N; i++) begin
      src[i] = NW'(test_data_FFtoAA[i].y_source) * NW'(XN) + NW'(test_data_FFtoAA[i].x_source);
      test_update[i] = i != 0 && test_en_SCtoFF[i] && test_data_FFtoAA[i].ant && !test_data_FFtoAA[i].backward;
    end
    for (int i = 1; i < N; i++)
      if (test_update[i] && !row_hit[src[i]]) begin
        row_hit[src[i]] = 1'b1;
        for (int e = 0; e < N - 1; e++)
          ph_nxt[src[i]][e] = e == i - 1 ?
            (ph[src[i]][e] > PH_MAX - D'(4) ? PH_MAX : ph[src[i]][e] + D'(4)) :
            (ph[src[i]][e] == '0 ? '0 : ph[src[i]][e] - D'(1));
      end
  end

  // pheromone table
  always_ff @(posedge clk)
    ph <= !reset_n ? {NODES*(N-1){PH_INIT}} : ph_nxt;
`else
  assign ph = {NODES*(N-1){PH_INIT}};
  assign test_update = '0;
`endif

  // table extremes
  always_comb begin
    ph_max_v = '0;
    ph_min_v = '1;
    for (int n = 0; n < NODES; n++)
      for (int e = 0; e < N - 1; e++) begin
        ph_max_v = ph[n][e] > ph_max_v ? ph[n][e] : ph_max_v;
        ph_min_v = ph[n][e] < ph_min_v ? ph[n][e] : ph_min_v;
      end
  end

  assign test_pheromones = ph;
  assign test_max_pheromone_value = ph_max_v;
  assign test_min_pheromone_value = ph_min_v;
endmodule

// File: tb/tb_mesh_router.sv
// tb_mesh_router: vector table plus corner sequences, outputs checked against a per-output scoreboard
module tb_mesh_router;
  import mesh_router_pkg::*;

`ifdef ANT_ROUTING_EN
  localparam bit ANT = 1'b1;
`else
  localparam bit ANT = 1'b0;
`endif
  localparam int INIT = 1 << (D - 1);

  typedef struct {
    int port;
    int xd;
    int yd;
    int out;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  packet_t [0:4] i_data, o_data, ff, aa;
  logic [0:4] i_data_val, o_en, o_data_val, i_en, en_sc, ffv, aav, upd, cn;
  logic [0:4][0:4] req_aa, req_rc, lreq, rreq;
  logic [0:NODES-1][0:3][D-1:0] ph;
  logic [0:D-1] phmax, phmin;

  int total = 0;
  int bad = 0;
  packet_t exp_q [5][$];
  packet_t p, q, mp;
  vec_t tbl [9];

  always #5 clk = ~clk;

  mesh_router #(.X_LOC(2), .Y_LOC(1)) dut (
    .clk(clk), .reset_n(reset_n), .i_data(i_data), .i_data_val(i_data_val), .o_en(o_en),
    .o_data(o_data), .o_data_val(o_data_val), .i_en(i_en), .test_en_SCtoFF(en_sc),
    .test_data_FFtoAA(ff), .test_data_val_FFtoAA(ffv), .test_data_AAtoSW(aa),
    .test_data_val_AAtoRC(aav), .test_output_req_AAtoRC(req_aa), .test_output_req_RCtoSC(req_rc),
    .test_l_req_matrix_SC(lreq), .test_update(upd), .test_calculate_neighbor(cn),
    .test_r_o_output_req(rreq), .test_pheromones(ph), .test_max_pheromone_value(phmax),
    .test_min_pheromone_value(phmin)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic packet_t mk(input int xs, input int ys, input int xd, input int yd, input bit ant);
    packet_t r = '0;
    r.x_source = XW'(xs);
    r.y_source = YW'(ys);
    r.x_dest = XW'(xd);
    r.y_dest = YW'(yd);
    r.ant = ant;
    return r;
  endfunction

  task automatic do_reset;
    reset_n = 1'b0;
    i_data_val = '0;
    i_en = '1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int o = 0; o < 5; o++) exp_q[o].delete();
  endtask

  // scoreboard: every valid output must match the oldest expectation for that port
  always @(negedge clk)
    if (reset_n)
      for (int o = 0; o < 5; o++)
        if (o_data_val[o]) begin
          total++;
          if (exp_q[o].size() == 0) begin
            bad++;
            $display("FAIL out%0d unexpected actual=%h required=none", o, o_data[o]);
          end else begin
            mp = exp_q[o].pop_front();
            if (o_data[o] != mp) begin
              bad++;
              $display("FAIL out%0d data actual=%h required=%h", o, o_data[o], mp);
            end
          end
        end

  initial begin
    tbl[0] = '{0, 2, 1, 0};
    tbl[1] = '{2, 0, 3, 4};
    tbl[2] = '{2, 2, 3, 1};
    tbl[3] = '{1, 2, 0, 3};
    tbl[4] = '{3, 3, 1, 2};
    tbl[5] = '{4, 0, 1, 4};
    tbl[6] = '{0, 3, 0, 2};
    tbl[7] = '{0, 1, 3, 4};
    tbl[8] = '{3, 2, 1, 0};
    i_data = '0;
    i_data_val = '0;
    i_en = '1;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_o_en", int'(o_en), 31);
    chk("rst_val", int'(o_data_val), 0);
    chk("rst_data0", int'(o_data[0] != '0), 0);
    chk("rst_ph", int'(ph[9][2]), INIT);
    chk("rst_max", int'(phmax), INIT);
    chk("rst_min", int'(phmin), INIT);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (tbl[v]) begin
      p = mk(v % 4, (v + 1) % 4, tbl[v].xd, tbl[v].yd, 1'b0);
      i_data[tbl[v].port] = p;
      i_data_val[tbl[v].port] = 1'b1;
      exp_q[tbl[v].out].push_back(p);
      @(negedge clk);
      i_data_val = '0;
      chk($sformatf("xy%0d", v), int'(req_aa[tbl[v].port][tbl[v].out]), 1);
      chk($sformatf("pre%0d", v), int'(o_data_val[tbl[v].out]), 0);
      @(negedge clk);
      chk($sformatf("lat%0d", v), int'(o_data_val[tbl[v].out]), 1);
    end
    @(negedge clk);

    do_reset;
    for (int c = 0; c < 10; c++) begin
      if (c < 3)
        for (int k = 0; k < 3; k++) begin
          p = mk(c, k, 2, 1, 1'b0);
          i_data[k == 0 ? 1 : k + 2] = p;
          i_data_val[k == 0 ? 1 : k + 2] = 1'b1;
          exp_q[0].push_back(p);
        end
      else i_data_val = '0;
      @(negedge clk);
      if (c < 9) chk($sformatf("pop%0d", c), int'(en_sc), c % 3 == 0 ? 8 : c % 3 == 1 ? 2 : 1);
    end

    do_reset;
    i_en[2] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      p = mk(k % 4, 0, 3, 1, 1'b0);
      i_data[0] = p;
      i_data_val[0] = 1'b1;
      if (k < 4) exp_q[2].push_back(p);
      @(negedge clk);
      chk($sformatf("bp_en%0d", k), int'(o_en[0]), k < 3 ? 1 : 0);
    end
    i_data_val = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", k), int'(o_data_val[2]), 0);
    end
    i_en[2] = 1'b1;
    repeat (6) @(negedge clk);
    chk("bp_drain", exp_q[2].size(), 0);

    do_reset;
    p = mk(1, 2, 2, 1, 1'b1);
    p.x_memory[0] = 2'd1;
    p.y_memory[0] = 2'd2;
    p.num_memories = 3'd1;
    q = p;
    if (ANT) begin
      q.x_memory[1] = 2'd2;
      q.y_memory[1] = 2'd1;
      q.num_memories = 3'd2;
    end
    i_data[1] = p;
    i_data_val[1] = 1'b1;
    exp_q[0].push_back(q);
    @(negedge clk);
    i_data_val = '0;
    chk("ant_upd", int'(upd[1]), ANT ? 1 : 0);
    chk("ant_pop", int'(en_sc[1]), 1);
    @(negedge clk);
    chk("ant_ph0", int'(ph[2 * XN + 1][0]), ANT ? INIT + 4 : INIT);
    chk("ant_ph1", int'(ph[2 * XN + 1][1]), ANT ? INIT - 1 : INIT);
    chk("ant_ph3", int'(ph[2 * XN + 1][3]), ANT ? INIT - 1 : INIT);
    chk("ant_max", int'(phmax), ANT ? INIT + 4 : INIT);
    chk("ant_min", int'(phmin), ANT ? INIT - 1 : INIT);
    chk("ant_upd_off", int'(upd), 0);

    do_reset;
    p = mk(0, 0, 3, 2, 1'b0);
    i_data[0] = p;
    i_data_val[0] = 1'b1;
    exp_q[2].push_back(p);
    @(negedge clk);
    i_data_val = '0;
    chk("tie_cn", int'(cn[0]), ANT ? 1 : 0);
    chk("tie_req", int'(req_rc[0][2]), 1);
    @(negedge clk);
    p = mk(3, 2, 2, 1, 1'b1);
    q = p;
    if (ANT) begin
      q.x_memory[0] = 2'd2;
      q.y_memory[0] = 2'd1;
      q.num_memories = 3'd1;
    end
    i_data[1] = p;
    i_data_val[1] = 1'b1;
    exp_q[0].push_back(q);
    @(negedge clk);
    i_data_val = '0;
    @(negedge clk);
    p = mk(1, 1, 3, 2, 1'b0);
    i_data[0] = p;
    i_data_val[0] = 1'b1;
    exp_q[ANT ? 1 : 2].push_back(p);
    @(negedge clk);
    i_data_val = '0;
    chk("ad_cn", int'(cn[0]), ANT ? 1 : 0);
    chk("ad_req", int'(rreq[0][ANT ? 1 : 2]), 1);
    chk("ad_xy", int'(req_aa[0][2]), 1);
    repeat (2) @(negedge clk);

    i_en = '0;
    for (int k = 0; k < 2; k++) begin
      i_data[3] = mk(k, 0, 0, 1, 1'b0);
      i_data_val[3] = 1'b1;
      @(negedge clk);
    end
    i_data_val = '0;
    chk("rt_queued", int'(ffv[3]), 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rt_empty", int'(ffv), 0);
    chk("rt_o_en", int'(o_en), 31);
    reset_n = 1'b1;
    i_en = '1;
    repeat (3) @(negedge clk);
    chk("rt_quiet", int'(o_data_val), 0);

    for (int o = 0; o < 5; o++) chk($sformatf("left%0d", o), exp_q[o].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
